// File: rtl/button_conditioner_if.sv
// Button pin and conditioned outputs bundled between the pin, the conditioner
// and the game FSM that consumes the clean pulses.
interface button_conditioner_if;
    logic       button_raw;
    logic       btn_level;
    logic       btn_press;
    logic       btn_release;
    logic       btn_long;
    logic [7:0] press_count;

    // master: the conditioner; slave: whoever drives the pin and consumes pulses
    modport master (
        input  button_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_long,
        output press_count
    );

    modport slave (
        output button_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_long,
        input  press_count
    );
endinterface

// File: rtl/button_conditioner.sv
// Push-button front-end: two-flop synchroniser, debounce FSM, and registered
// press / release / long-press pulses with a debounced level and press counter.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 120000,
    parameter int LONG_PRESS_CYCLES = 24000000,
    parameter int ACTIVE_LOW        = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    button_conditioner_if.master btn
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_SAT = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic INV = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {IDLE, PRESS_Q, HELD, REL_Q} state_t;

    state_t        state,      stateNext;
    logic [DW-1:0] dcnt,       dcntNext;
    logic [HW-1:0] hcnt,       hcntNext;
    logic          level,      levelNext;
    logic          press,      pressNext;
    logic          rel,        relNext;
    logic          longPress,  longNext;
    logic [7:0]    count,      countNext;
    logic [1:0]    syncPipe;
    logic          s;

    // Inversion happens ahead of the synchroniser so reset (0) is always "released".
    always_ff @(posedge clk) begin
        if (rst) syncPipe <= '0;
        else     syncPipe <= {syncPipe[0], btn.button_raw ^ INV};
    end
    assign s = syncPipe[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dcnt      <= '0;
            hcnt      <= '0;
            level     <= 1'b0;
            press     <= 1'b0;
            rel       <= 1'b0;
            longPress <= 1'b0;
            count     <= '0;
        end else begin
            state     <= stateNext;
            dcnt      <= dcntNext;
            hcnt      <= hcntNext;
            level     <= levelNext;
            press     <= pressNext;
            rel       <= relNext;
            longPress <= longNext;
            count     <= countNext;
        end
    end

    always_comb begin
        stateNext = state;
        dcntNext  = dcnt;
        hcntNext  = hcnt;
        levelNext = level;
        pressNext = 1'b0;
        relNext   = 1'b0;
        longNext  = 1'b0;
        countNext = count;

        // Hold timer runs through release qualification so a bounce keeps the
        // press's age; saturation makes the long pulse one-shot.
        if ((state == HELD || state == REL_Q) && hcnt != HOLD_SAT) begin
            hcntNext = hcnt + 1'b1;
            longNext = (hcntNext == HOLD_SAT);
        end

        case (state)
            IDLE: begin
                if (s) begin
                    stateNext = PRESS_Q;
                    dcntNext  = '0;
                end
            end
            PRESS_Q: begin
                if (!s) begin
                    stateNext = IDLE;
                end else if (dcnt == DEB_LAST) begin
                    stateNext = HELD;
                    levelNext = 1'b1;
                    pressNext = 1'b1;
                    countNext = count + 8'd1;
                    hcntNext  = '0;
                end else begin
                    dcntNext  = dcnt + 1'b1;
                end
            end
            HELD: begin
                if (!s) begin
                    stateNext = REL_Q;
                    dcntNext  = '0;
                end
            end
            REL_Q: begin
                if (s) begin
                    stateNext = HELD;
                end else if (dcnt == DEB_LAST) begin
                    stateNext = IDLE;
                    levelNext = 1'b0;
                    relNext   = 1'b1;
                end else begin
                    dcntNext  = dcnt + 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign btn.btn_level   = level;
    assign btn.btn_press   = press;
    assign btn.btn_release = rel;
    assign btn.btn_long    = longPress;
    assign btn.press_count = count;
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench: stimulus pushes expected pulse events (kind, cycle, level,
// count) to a queue; a negedge monitor pops and compares every observed pulse.
module tb_button_conditioner;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int K_PRESS = 0, K_REL = 1, K_LONG = 2;

    typedef struct {
        int         kind;
        int         cyc;
        bit         lvl;
        logic [7:0] cnt;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    ev_t  expQ[$];
    logic [7:0] expCount = 8'd0;
    bit   seen2 = 1'b0;

    button_conditioner_if btn ();
    button_conditioner_if btn2 ();

    button_conditioner #(.DEBOUNCE_CYCLES(DEB), .LONG_PRESS_CYCLES(LONG), .ACTIVE_LOW(0)) dut (
        .clk (clk),
        .rst (rst),
        .btn (btn.master)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEB), .LONG_PRESS_CYCLES(LONG), .ACTIVE_LOW(1)) dutLow (
        .clk (clk),
        .rst (rst),
        .btn (btn2.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, int act, int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic pushEv(int kind, int c, bit lvl, logic [7:0] cnt);
        ev_t e;
        e.kind = kind; e.cyc = c; e.lvl = lvl; e.cnt = cnt;
        expQ.push_back(e);
    endtask

    task automatic popEv(int kind);
        ev_t e;
        vectors++;
        if (expQ.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected pulse kind %0d at cycle %0d: got pulse, expected none", kind, cyc);
            return;
        end
        e = expQ.pop_front();
        if (e.kind != kind || e.cyc != cyc || e.lvl != btn.btn_level || e.cnt != btn.press_count) begin
            miscompares++;
            $display("FAIL pulse event: got kind %0d cyc %0d lvl %0b cnt %0d, expected kind %0d cyc %0d lvl %0b cnt %0d",
                     kind, cyc, btn.btn_level, btn.press_count, e.kind, e.cyc, e.lvl, e.cnt);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (btn.btn_press && btn.btn_release)
                check("press_and_release_together", 1, 0);
            if (btn.btn_press)   popEv(K_PRESS);
            if (btn.btn_release) popEv(K_REL);
            if (btn.btn_long)    popEv(K_LONG);
            if (btn2.btn_press || btn2.btn_release || btn2.btn_long || btn2.btn_level)
                seen2 = 1'b1;
        end
    end

    task automatic waitCyc(int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Drive at a negedge; returns the index of the first posedge that samples it.
    task automatic setRaw(bit v, output int e0);
        @(negedge clk);
        btn.button_raw = v;
        e0 = cyc + 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog at cycle %0d: got timeout, expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, e1, r0;
        btn.button_raw  = 1'b0;
        btn2.button_raw = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_level", btn.btn_level, 0);
        check("reset_count", btn.press_count, 0);
        check("reset_pulses", {btn.btn_press, btn.btn_release, btn.btn_long}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Clean press, bounce while held, long press, release
        setRaw(1'b1, e0);
        expCount = expCount + 8'd1;
        pushEv(K_PRESS, e0 + 6, 1'b1, expCount);
        pushEv(K_LONG, e0 + 6 + 19, 1'b1, expCount);
        waitCyc(e0 + 5);
        check("level_before_accept", btn.btn_level, 0);
        waitCyc(e0 + 6);
        check("level_at_accept", btn.btn_level, 1);
        check("count_first_press", btn.press_count, 1);
        waitCyc(e0 + 8);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            btn.button_raw = (i % 2 == 1);
        end
        waitCyc(e0 + 20);
        check("level_after_bounce", btn.btn_level, 1);
        waitCyc(e0 + 40);
        setRaw(1'b0, e1);
        pushEv(K_REL, e1 + 6, 1'b0, expCount);
        waitCyc(e1 + 5);
        check("level_before_release", btn.btn_level, 1);
        waitCyc(e1 + 10);
        check("level_released", btn.btn_level, 0);

        // Short glitch, 3 cycles high
        setRaw(1'b1, e0);
        repeat (3) @(negedge clk);
        btn.button_raw = 1'b0;
        waitCyc(e0 + 15);
        check("glitch_level", btn.btn_level, 0);
        check("glitch_count", btn.press_count, expCount);

        // Reset mid-press: no release, fresh press after reset
        setRaw(1'b1, e0);
        expCount = expCount + 8'd1;
        pushEv(K_PRESS, e0 + 6, 1'b1, expCount);
        waitCyc(e0 + 10);
        check("count_before_reset", btn.press_count, 2);
        rst = 1'b1;
        @(negedge clk);
        check("rst_level", btn.btn_level, 0);
        check("rst_count", btn.press_count, 0);
        check("rst_pulses", {btn.btn_press, btn.btn_release, btn.btn_long}, 0);
        rst = 1'b0;
        r0 = cyc + 1;
        expCount = 8'd1;
        pushEv(K_PRESS, r0 + 6, 1'b1, expCount);
        waitCyc(r0 + 8);
        setRaw(1'b0, e1);
        pushEv(K_REL, e1 + 6, 1'b0, expCount);
        waitCyc(e1 + 8);

        // 255 more clean presses: counter wraps 255 -> 0
        for (int k = 0; k < 255; k++) begin
            setRaw(1'b1, e0);
            expCount = expCount + 8'd1;
            pushEv(K_PRESS, e0 + 6, 1'b1, expCount);
            waitCyc(e0 + 8);
            setRaw(1'b0, e1);
            pushEv(K_REL, e1 + 6, 1'b0, expCount);
            waitCyc(e1 + 8);
        end
        check("count_wrapped", btn.press_count, 0);

        // Active-low instance: idle-high pin stays quiet, low pin is a press
        check("active_low_quiet", seen2, 0);
        check("active_low_count_idle", btn2.press_count, 0);
        @(negedge clk);
        btn2.button_raw = 1'b0;
        e0 = cyc + 1;
        waitCyc(e0 + 5);
        check("active_low_not_yet", btn2.btn_level, 0);
        waitCyc(e0 + 6);
        check("active_low_press", btn2.btn_press, 1);
        check("active_low_count", btn2.press_count, 1);
        repeat (3) @(negedge clk);

        while (expQ.size() != 0) begin
            ev_t e;
            e = expQ.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing pulse: got none, expected kind %0d at cycle %0d", e.kind, e.cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
